// File: rtl/lvds_echo_mem_master_if.sv
// rtl/lvds_echo_mem_master_if.sv - command, capture/replay stream and Avalon-MM bundle for lvds_echo_mem_master
interface lvds_echo_mem_master_if #(
    parameter int ADDR_W = 13
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_read;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic [31:0]       snk_data;
    logic              snk_valid;
    logic              snk_ready;
    logic [31:0]       src_data;
    logic              src_valid;
    logic              src_ready;
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;

    modport master (
        input  cmd_valid, cmd_read, cmd_base, cmd_len, snk_data, snk_valid, src_ready,
               avm_waitrequest, avm_readdata, avm_readdatavalid,
        output cmd_ready, snk_ready, src_data, src_valid, avm_address, avm_read, avm_write,
               avm_writedata, avm_byteenable, busy, done, checksum
    );

    modport slave (
        output cmd_valid, cmd_read, cmd_base, cmd_len, snk_data, snk_valid, src_ready,
               avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  cmd_ready, snk_ready, src_data, src_valid, avm_address, avm_read, avm_write,
               avm_writedata, avm_byteenable, busy, done, checksum
    );
endinterface

// File: rtl/lvds_echo_mem_master.sv
// rtl/lvds_echo_mem_master.sv - capture/replay memory master; optional checksum via LVDS_ECHO_MEM_MASTER_CHECKSUM_EN
module lvds_echo_mem_master #(
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    lvds_echo_mem_master_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CAPTURE, REPLAY, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   snk_left;
    logic              wr_q;
    logic [31:0]       wdata;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [31:0]       fifo_mem [FIFO_DEPTH];

    logic cmd_fire, snk_fire, wr_acc, rd_acc, push, pop;
    logic cmd_ready_c, busy_c, done_c, snk_ready_c, rd_en;

    assign cmd_fire = bus.cmd_valid && (state == IDLE);
    assign snk_fire = bus.snk_valid && snk_ready_c;
    assign wr_acc   = wr_q && !bus.avm_waitrequest;
    assign rd_acc   = rd_en && !bus.avm_waitrequest;
    // A response with nothing outstanding is a leftover from before reset.
    assign push     = bus.avm_readdatavalid && (outstanding != '0);
    assign pop      = (fifo_count != '0) && bus.src_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0)  state_nxt = DONE;
                    else if (bus.cmd_read)  state_nxt = REPLAY;
                    else                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: if (wr_acc && remaining == (ADDR_W+1)'(1)) state_nxt = DONE;
            REPLAY:  if (rd_acc && remaining == (ADDR_W+1)'(1)) state_nxt = DRAIN;
            DRAIN:   if (outstanding == '0 && fifo_count == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_c = 1'b0;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        snk_ready_c = 1'b0;
        rd_en       = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                busy_c      = 1'b0;
            end
            CAPTURE: snk_ready_c = (snk_left != '0) && (!wr_q || !bus.avm_waitrequest);
            // Reads in flight plus buffered words never exceed the buffer, so pushes always fit.
            REPLAY:  rd_en = (remaining != '0) &&
                             (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.cmd_ready      = cmd_ready_c;
    assign bus.busy           = busy_c;
    assign bus.done           = done_c;
    assign bus.snk_ready      = snk_ready_c;
    assign bus.avm_read       = rd_en;
    assign bus.avm_write      = wr_q;
    assign bus.avm_writedata  = wdata;
    assign bus.avm_address    = {addr, 2'b00};
    assign bus.avm_byteenable = 4'hF;
    assign bus.src_valid      = (fifo_count != '0);
    assign bus.src_data       = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr        <= '0;
            remaining   <= '0;
            snk_left    <= '0;
            wr_q        <= 1'b0;
            wdata       <= '0;
            outstanding <= '0;
        end else begin
            if (cmd_fire) begin
                addr      <= bus.cmd_base;
                remaining <= bus.cmd_len;
                snk_left  <= bus.cmd_len;
            end else begin
                if (wr_acc || rd_acc) begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
                end
                if (snk_fire) snk_left <= snk_left - (ADDR_W+1)'(1);
            end
            if (snk_fire) begin
                wr_q  <= 1'b1;
                wdata <= bus.snk_data;
            end else if (wr_acc) begin
                wr_q  <= 1'b0;
            end
            unique case ({rd_acc, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.avm_readdata;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

`ifdef LVDS_ECHO_MEM_MASTER_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     csum <= '0;
        else if (cmd_fire) csum <= '0;
        else if (wr_acc)   csum <= csum ^ wdata;
        else if (pop)      csum <= csum ^ bus.src_data;
    end

    assign bus.checksum = csum;
`else
    assign bus.checksum = 32'h0;
`endif
endmodule

// File: tb/tb_lvds_echo_mem_master.sv
// tb/tb_lvds_echo_mem_master.sv - scoreboard bench for lvds_echo_mem_master
module tb_lvds_echo_mem_master;
    localparam int AW = 13;
    localparam int FD = 4;

    typedef struct packed {
        logic [AW+1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lvds_echo_mem_master_if #(.ADDR_W(AW)) bus ();

    lvds_echo_mem_master #(.ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    wr_t         exp_wr_q[$];
    logic [31:0] snk_q[$];
    logic [31:0] exp_src_q[$];
    logic [31:0] mem [0:(1<<AW)-1];

    int   cyc = 0, done_cnt = 0, wr_count = 0;
    int   stall_idx = -1, stall_len = 0, stall_left = 0, stall_seen = 0;
    bit   stall_used = 1'b0;
    bit   rd_pend = 1'b0;
    logic [31:0] rd_data;
    int   rd_issued = 0, src_popped = 0, max_inflight = 0;
    int   first_beat = -1, last_beat = -1;
    bit   src_rdy_en = 1'b1;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0000_9E37);
    endfunction

    function automatic logic [31:0] exp_cs(input logic [31:0] cs);
`ifdef LVDS_ECHO_MEM_MASTER_CHECKSUM_EN
        return cs;
`else
        return 32'h0 & cs;
`endif
    endfunction

    // Slave memory model and stream endpoints: drive at negedge, observe handshakes 1 ns later.
    initial begin
        wr_t e;
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        bus.snk_valid         = 1'b0;
        bus.snk_data          = '0;
        bus.src_ready         = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.avm_readdatavalid = rd_pend;
            bus.avm_readdata      = rd_pend ? rd_data : $urandom;
            rd_pend = 1'b0;
            if (bus.avm_write && wr_count == stall_idx && !stall_used) begin
                stall_left = stall_len;
                stall_used = 1'b1;
            end
            bus.avm_waitrequest = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            bus.snk_valid = (snk_q.size() != 0);
            bus.snk_data  = (snk_q.size() != 0) ? snk_q[0] : 32'h0;
            bus.src_ready = src_rdy_en;
            #1;
            if (bus.done) done_cnt++;
            if (bus.avm_write && bus.avm_waitrequest && exp_wr_q.size() != 0) begin
                stall_seen++;
                check("stall_addr", bus.avm_address, exp_wr_q[0].addr);
                check("stall_data", bus.avm_writedata, exp_wr_q[0].data);
            end
            if (bus.avm_write && !bus.avm_waitrequest) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", bus.avm_address, 64'hFFFF_FFFF);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", bus.avm_address, e.addr);
                    check("wr_data", bus.avm_writedata, e.data);
                end
                mem[bus.avm_address[AW+1:2]] = bus.avm_writedata;
                wr_count++;
            end
            if (bus.avm_read && !bus.avm_waitrequest) begin
                rd_pend = 1'b1;
                rd_data = mem[bus.avm_address[AW+1:2]];
                rd_issued++;
            end
            if (bus.snk_valid && bus.snk_ready) snk_q.delete(0);
            if (bus.src_valid && bus.src_ready) begin
                if (exp_src_q.size() == 0) check("src_unexpected", bus.src_data, 64'hFFFF_FFFF_FFFF);
                else                       check("src_data", bus.src_data, exp_src_q.pop_front());
                src_popped++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            if (rd_issued - src_popped > max_inflight) max_inflight = rd_issued - src_popped;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_avm_read"}, bus.avm_read, 0);
        check({tag, "_avm_write"}, bus.avm_write, 0);
        check({tag, "_avm_address"}, bus.avm_address, 0);
        check({tag, "_avm_writedata"}, bus.avm_writedata, 0);
        check({tag, "_snk_ready"}, bus.snk_ready, 0);
        check({tag, "_src_valid"}, bus.src_valid, 0);
        check({tag, "_checksum"}, bus.checksum, 0);
    endtask

    task automatic issue_cmd(input bit rd, input int base, input int len, input string tag, output int d0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = rd;
        bus.cmd_base  = AW'(base);
        bus.cmd_len   = (AW+1)'(len);
        #2;
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        d0 = done_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < 500) begin
            @(negedge clk);
            #2;
            k++;
        end
        repeat (3) @(negedge clk);
        #2;
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic capture(input int base, input int len, input bit count_up, input int stall_at, input string tag);
        logic [31:0] w;
        logic [31:0] cs = '0;
        int d0;
        wr_count = 0; stall_idx = stall_at; stall_len = 3; stall_used = 1'b0; stall_seen = 0;
        for (int i = 0; i < len; i++) begin
            w = count_up ? 32'(i + 1) : $urandom;
            snk_q.push_back(w);
            exp_wr_q.push_back('{addr: (AW+2)'(((base + i) % (1 << AW)) * 4), data: w});
            cs ^= w;
        end
        issue_cmd(1'b0, base, len, tag, d0);
        wait_done(d0, tag);
        check({tag, "_wr_left"}, exp_wr_q.size(), 0);
        check({tag, "_snk_left"}, snk_q.size(), 0);
        check({tag, "_checksum"}, bus.checksum, exp_cs(cs));
    endtask

    task automatic prep_replay(input int base, input int len, output logic [31:0] cs);
        cs = '0;
        rd_issued = 0; src_popped = 0; max_inflight = 0; first_beat = -1; last_beat = -1;
        for (int i = 0; i < len; i++) begin
            exp_src_q.push_back(pat((base + i) % (1 << AW)));
            cs ^= pat((base + i) % (1 << AW));
        end
    endtask

    initial begin
        int d0;
        int k;
        logic [31:0] cs;
        bus.cmd_valid = 1'b0;
        bus.cmd_read  = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        repeat (3) @(negedge clk);
        #2;
        check_reset("rst");
        check("byteenable", bus.avm_byteenable, 4'hF);
        @(negedge clk);
        reset_n = 1'b1;

        capture(0, 4, 1'b1, -1, "cap");
        capture(8190, 4, 1'b0, -1, "wrap");
        capture(100, 4, 1'b0, 1, "stall");
        check("stall_cycles", stall_seen, 3);

        wr_count = 0;
        issue_cmd(1'b0, 5, 0, "len0", d0);
        wait_done(d0, "len0");
        check("len0_no_writes", wr_count, 0);

        src_rdy_en = 1'b1;
        prep_replay(200, 8, cs);
        issue_cmd(1'b1, 200, 8, "rep", d0);
        wait_done(d0, "rep");
        check("rep_src_left", exp_src_q.size(), 0);
        check("rep_beats", src_popped, 8);
        check("rep_back_to_back", last_beat - first_beat, 7);
        check("rep_inflight_cap", max_inflight <= FD, 1);
        check("rep_checksum", bus.checksum, exp_cs(cs));

        prep_replay(300, 8, cs);
        src_rdy_en = 1'b0;
        issue_cmd(1'b1, 300, 8, "bp", d0);
        repeat (20) @(negedge clk);
        #2;
        check("bp_reads_capped", rd_issued, FD);
        check("bp_no_beats", src_popped, 0);
        src_rdy_en = 1'b1;
        wait_done(d0, "bp");
        check("bp_src_left", exp_src_q.size(), 0);
        check("bp_inflight_cap", max_inflight <= FD, 1);
        check("bp_checksum", bus.checksum, exp_cs(cs));

        prep_replay(400, 8, cs);
        issue_cmd(1'b1, 400, 8, "mid", d0);
        k = 0;
        while (src_popped < 2 && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("mid_two_beats", src_popped >= 2, 1);
        @(negedge clk);
        reset_n = 1'b0;
        exp_src_q.delete();
        #2;
        check_reset("mid_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        prep_replay(500, 1, cs);
        issue_cmd(1'b1, 500, 1, "post", d0);
        wait_done(d0, "post");
        check("post_src_left", exp_src_q.size(), 0);
        check("post_beats", src_popped, 1);
        check("post_checksum", bus.checksum, exp_cs(cs));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
